// File: rtl/xbus_pkg.sv
// Shared XBUS widths, FSM state encodings and the decode-miss channel code.
package xbus_pkg;

    localparam int unsigned ADR_W = 32;
    localparam int unsigned DAT_W = 32;
    localparam int unsigned TAG_W = 3;
    localparam int unsigned SEL_W = 4;

    localparam logic [3:0] ERR_CH_MISS = 4'hF;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StWait = 2'd2;
    localparam logic [1:0] StResp = 2'd3;

endpackage

// File: rtl/xbus_addr_decode.sv
// Combinational address decoder: maps an address to a channel inside the fabric window.
module xbus_addr_decode
    import xbus_pkg::*;
#(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned CH_AW     = 16,
    parameter logic [31:0] BASE_ADDR = 32'hF000_0000
) (
    input  logic [ADR_W-1:0] adr_i,
    output logic             hit_o,
    output logic [3:0]       ch_o,
    output logic [N_CH-1:0]  ch_oh_o
);

    // A single-channel fabric still spends one address bit on the channel index.
    localparam int unsigned CW  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned TOP = CH_AW + CW;

    logic [ADR_W-1:0] idx;
    logic             tag_match;

    always_comb begin
        idx       = (adr_i >> CH_AW) & ((ADR_W'(1) << CW) - ADR_W'(1));
        tag_match = (adr_i >> TOP) == (BASE_ADDR >> TOP);
        hit_o     = tag_match && (idx < ADR_W'(N_CH));
        ch_o      = idx[3:0];
        ch_oh_o   = '0;
        for (int k = 0; k < int'(N_CH); k++) begin
            ch_oh_o[k] = hit_o && (idx == ADR_W'(k));
        end
    end

endmodule

// File: rtl/xbus_interconnect.sv
// XBUS fabric: one master to N_CH slaves, one outstanding access, fully registered outputs.
// Optional slave timeout is enabled with the XBUS_TIMEOUT_EN macro.
module xbus_interconnect
    import xbus_pkg::*;
#(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned CH_AW     = 16,
    parameter logic [31:0] BASE_ADDR = 32'hF000_0000,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [ADR_W-1:0]       m_adr_i,
    input  logic [DAT_W-1:0]       m_dat_i,
    input  logic [TAG_W-1:0]       m_tag_i,
    input  logic                   m_we_i,
    input  logic [SEL_W-1:0]       m_sel_i,
    input  logic                   m_stb_i,
    input  logic                   m_cyc_i,
    output logic [DAT_W-1:0]       m_dat_o,
    output logic                   m_ack_o,
    output logic                   m_err_o,
    output logic [ADR_W-1:0]       s_adr_o,
    output logic [DAT_W-1:0]       s_dat_o,
    output logic [TAG_W-1:0]       s_tag_o,
    output logic                   s_we_o,
    output logic [SEL_W-1:0]       s_sel_o,
    output logic [N_CH-1:0]        s_stb_o,
    output logic [N_CH-1:0]        s_cyc_o,
    input  logic [DAT_W*N_CH-1:0]  s_dat_i,
    input  logic [N_CH-1:0]        s_ack_i,
    input  logic [N_CH-1:0]        s_err_i,
    output logic [3:0]             err_ch_o
);

    logic [1:0]       state_q, state_d;
    logic             miss_q, miss_d;
    logic [3:0]       ch_q, ch_d, err_ch_q, err_ch_d;
    logic [N_CH-1:0]  ch_oh_q, ch_oh_d, s_stb_q, s_stb_d, s_cyc_q, s_cyc_d;
    logic             m_ack_q, m_ack_d, m_err_q, m_err_d;
    logic [DAT_W-1:0] m_dat_q, m_dat_d, dat_q, rd_dat;
    logic [ADR_W-1:0] adr_q;
    logic [TAG_W-1:0] tag_q;
    logic [SEL_W-1:0] sel_q;
    logic             we_q, latch;
    logic             dec_hit, sel_ack, sel_err;
    logic [3:0]       dec_ch;
    logic [N_CH-1:0]  dec_oh;

`ifdef XBUS_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    xbus_addr_decode #(
        .N_CH      (N_CH),
        .CH_AW     (CH_AW),
        .BASE_ADDR (BASE_ADDR)
    ) u_decode (
        .adr_i   (m_adr_i),
        .hit_o   (dec_hit),
        .ch_o    (dec_ch),
        .ch_oh_o (dec_oh)
    );

    always_comb begin
        sel_ack = |(s_ack_i & ch_oh_q);
        sel_err = |(s_err_i & ch_oh_q);
        rd_dat  = '0;
        for (int k = 0; k < int'(N_CH); k++) begin
            if (ch_oh_q[k]) rd_dat = rd_dat | s_dat_i[DAT_W*k +: DAT_W];
        end
    end

    always_comb begin
        state_d  = state_q;
        miss_d   = miss_q;
        ch_d     = ch_q;
        ch_oh_d  = ch_oh_q;
        err_ch_d = err_ch_q;
        s_stb_d  = '0;
        s_cyc_d  = s_cyc_q;
        m_ack_d  = 1'b0;
        m_err_d  = 1'b0;
        m_dat_d  = '0;
        latch    = 1'b0;
`ifdef XBUS_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            StIdle: begin
                if (m_stb_i) begin
                    latch = 1'b1;
                    if (dec_hit) begin
                        ch_d    = dec_ch;
                        ch_oh_d = dec_oh;
                        s_stb_d = dec_oh;
                        s_cyc_d = dec_oh;
`ifdef XBUS_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                        state_d = StReq;
                    end else begin
                        miss_d  = 1'b1;
                        state_d = StResp;
                    end
                end
            end
            StReq: begin
                if (!m_cyc_i) begin
                    s_cyc_d = '0;
                    state_d = StIdle;
                end else begin
                    state_d = StWait;
                end
            end
            StWait: begin
                // Abort beats any slave response arriving in the same cycle.
                if (!m_cyc_i) begin
                    s_cyc_d = '0;
                    state_d = StIdle;
                end else if (sel_err) begin
                    m_err_d  = 1'b1;
                    err_ch_d = ch_q;
                    s_cyc_d  = '0;
                    state_d  = StResp;
                end else if (sel_ack) begin
                    m_ack_d = 1'b1;
                    m_dat_d = we_q ? '0 : rd_dat;
                    s_cyc_d = '0;
                    state_d = StResp;
`ifdef XBUS_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    m_err_d  = 1'b1;
                    err_ch_d = ch_q;
                    s_cyc_d  = '0;
                    state_d  = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            StResp: begin
                // A decode miss spends one extra RESP cycle so its error lands at cycle 2.
                if (miss_q) begin
                    m_err_d  = 1'b1;
                    err_ch_d = ERR_CH_MISS;
                    miss_d   = 1'b0;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            miss_q   <= 1'b0;
            ch_q     <= '0;
            ch_oh_q  <= '0;
            err_ch_q <= '0;
            s_stb_q  <= '0;
            s_cyc_q  <= '0;
            m_ack_q  <= 1'b0;
            m_err_q  <= 1'b0;
            m_dat_q  <= '0;
            adr_q    <= '0;
            dat_q    <= '0;
            tag_q    <= '0;
            we_q     <= 1'b0;
            sel_q    <= '0;
`ifdef XBUS_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            miss_q   <= miss_d;
            ch_q     <= ch_d;
            ch_oh_q  <= ch_oh_d;
            err_ch_q <= err_ch_d;
            s_stb_q  <= s_stb_d;
            s_cyc_q  <= s_cyc_d;
            m_ack_q  <= m_ack_d;
            m_err_q  <= m_err_d;
            m_dat_q  <= m_dat_d;
`ifdef XBUS_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
            if (latch) begin
                adr_q <= m_adr_i;
                dat_q <= m_dat_i;
                tag_q <= m_tag_i;
                we_q  <= m_we_i;
                sel_q <= m_sel_i;
            end
        end
    end

    assign m_dat_o  = m_dat_q;
    assign m_ack_o  = m_ack_q;
    assign m_err_o  = m_err_q;
    assign s_adr_o  = adr_q;
    assign s_dat_o  = dat_q;
    assign s_tag_o  = tag_q;
    assign s_we_o   = we_q;
    assign s_sel_o  = sel_q;
    assign s_stb_o  = s_stb_q;
    assign s_cyc_o  = s_cyc_q;
    assign err_ch_o = err_ch_q;

endmodule

// File: tb/tb_xbus_interconnect.sv
// Directed self-checking bench for xbus_interconnect (N_CH=4, TIMEOUT=10).
module tb_xbus_interconnect;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  m_adr, m_dat;
    logic [2:0]   m_tag;
    logic         m_we, m_stb, m_cyc;
    logic [3:0]   m_sel;
    logic [31:0]  m_rdat, s_adr, s_dat;
    logic         m_ack, m_err, s_we;
    logic [2:0]   s_tag;
    logic [3:0]   s_sel, s_stb, s_cyc, s_ack, s_err, err_ch;
    logic [127:0] s_rdat;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    xbus_interconnect #(
        .N_CH      (4),
        .CH_AW     (16),
        .BASE_ADDR (32'hF000_0000),
        .TIMEOUT   (10)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .m_adr_i  (m_adr),
        .m_dat_i  (m_dat),
        .m_tag_i  (m_tag),
        .m_we_i   (m_we),
        .m_sel_i  (m_sel),
        .m_stb_i  (m_stb),
        .m_cyc_i  (m_cyc),
        .m_dat_o  (m_rdat),
        .m_ack_o  (m_ack),
        .m_err_o  (m_err),
        .s_adr_o  (s_adr),
        .s_dat_o  (s_dat),
        .s_tag_o  (s_tag),
        .s_we_o   (s_we),
        .s_sel_o  (s_sel),
        .s_stb_o  (s_stb),
        .s_cyc_o  (s_cyc),
        .s_dat_i  (s_rdat),
        .s_ack_i  (s_ack),
        .s_err_i  (s_err),
        .err_ch_o (err_ch)
    );

    task automatic tick;
        @(negedge clk);
    endtask

    // Drives a one-cycle strobe in the current cycle; returns in the middle of cycle 1.
    task automatic start(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                         input logic [3:0] sel, input logic [2:0] tag);
        m_adr = adr; m_dat = dat; m_we = we; m_sel = sel; m_tag = tag;
        m_stb = 1'b1; m_cyc = 1'b1;
        tick();
        m_stb = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(); tick();
        checks++; if ({m_ack, m_err, s_stb, s_cyc, err_ch} !== 14'd0) begin failures++;
            $display("FAIL reset_ctrl got %h want 0", {m_ack, m_err, s_stb, s_cyc, err_ch}); end
        checks++; if (m_rdat !== 32'd0) begin failures++;
            $display("FAIL reset_mdat got %h want 0", m_rdat); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_read;
        start(32'hF002_0010, 32'd0, 1'b0, 4'hF, 3'd0);
        checks++; if (s_stb !== 4'b0100) begin failures++;
            $display("FAIL read_stb got %b want 0100", s_stb); end
        checks++; if (s_adr !== 32'hF002_0010) begin failures++;
            $display("FAIL read_adr got %h want f0020010", s_adr); end
        tick();
        checks++; if ({s_stb, s_cyc, m_ack} !== 9'b0000_0100_0) begin failures++;
            $display("FAIL read_wait got %b want 000001000", {s_stb, s_cyc, m_ack}); end
        s_ack = 4'b0100; s_rdat[95:64] = 32'hCAFE_F00D;
        tick();
        s_ack = 4'b0000;
        checks++; if ({m_ack, m_err} !== 2'b10) begin failures++;
            $display("FAIL read_ack got %b want 10", {m_ack, m_err}); end
        checks++; if (m_rdat !== 32'hCAFE_F00D) begin failures++;
            $display("FAIL read_data got %h want cafef00d", m_rdat); end
        m_cyc = 1'b0;
        tick();
        checks++; if ({m_ack, m_rdat} !== 33'd0) begin failures++;
            $display("FAIL read_idle got %h want 0", {m_ack, m_rdat}); end
    endtask

    task automatic test_write;
        start(32'hF000_0004, 32'h1234_5678, 1'b1, 4'b0011, 3'b101);
        checks++; if ({s_stb, s_sel, s_we, s_tag} !== 12'b0001_0011_1_101) begin failures++;
            $display("FAIL write_fwd got %b want 000100111101", {s_stb, s_sel, s_we, s_tag}); end
        checks++; if (s_dat !== 32'h1234_5678) begin failures++;
            $display("FAIL write_dat got %h want 12345678", s_dat); end
        tick();
        s_ack = 4'b0001; s_rdat[31:0] = 32'hDEAD_BEEF;
        tick();
        s_ack = 4'b0000;
        checks++; if (m_ack !== 1'b1) begin failures++;
            $display("FAIL write_ack got %b want 1", m_ack); end
        checks++; if (m_rdat !== 32'd0) begin failures++;
            $display("FAIL write_mdat got %h want 0", m_rdat); end
        m_cyc = 1'b0;
        tick();
    endtask

    task automatic test_miss;
        start(32'h8000_0000, 32'd0, 1'b0, 4'hF, 3'd0);
        checks++; if ({s_stb, s_cyc, m_err} !== 9'd0) begin failures++;
            $display("FAIL miss_c1 got %b want 0", {s_stb, s_cyc, m_err}); end
        tick();
        checks++; if ({m_err, m_ack, err_ch} !== 6'b10_1111) begin failures++;
            $display("FAIL miss_err got %b want 101111", {m_err, m_ack, err_ch}); end
        m_cyc = 1'b0;
        tick();
        checks++; if (m_err !== 1'b0) begin failures++;
            $display("FAIL miss_pulse got %b want 0", m_err); end
    endtask

    task automatic test_slave_err;
        start(32'hF003_0000, 32'd0, 1'b0, 4'hF, 3'd0);
        tick();
        s_ack = 4'b1000; s_err = 4'b1000;
        tick();
        s_ack = 4'b0000; s_err = 4'b0000;
        checks++; if ({m_err, m_ack, err_ch} !== 6'b10_0011) begin failures++;
            $display("FAIL slverr got %b want 100011", {m_err, m_ack, err_ch}); end
        m_cyc = 1'b0;
        tick();
    endtask

    task automatic test_other_channel;
        start(32'hF001_0000, 32'd0, 1'b0, 4'hF, 3'd0);
        tick();
        s_ack = 4'b0001; s_err = 4'b0100;
        tick();
        s_ack = 4'b0000; s_err = 4'b0000;
        checks++; if ({m_ack, m_err, s_cyc} !== 6'b00_0010) begin failures++;
            $display("FAIL other_ch got %b want 000010", {m_ack, m_err, s_cyc}); end
        s_ack = 4'b0010; s_rdat[63:32] = 32'h0BAD_F00D;
        tick();
        s_ack = 4'b0000;
        checks++; if ({m_ack, m_rdat} !== {1'b1, 32'h0BAD_F00D}) begin failures++;
            $display("FAIL other_ack got %h want 10badf00d", {m_ack, m_rdat}); end
        m_cyc = 1'b0;
        tick();
    endtask

    task automatic test_abort;
        start(32'hF001_0000, 32'd0, 1'b0, 4'hF, 3'd0);
        tick();
        m_cyc = 1'b0;
        tick();
        checks++; if ({s_cyc, s_stb} !== 8'd0) begin failures++;
            $display("FAIL abort_cyc got %b want 0", {s_cyc, s_stb}); end
        s_ack = 4'b0010;
        tick();
        s_ack = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            checks++; if ({m_ack, m_err} !== 2'b00) begin failures++;
                $display("FAIL abort_resp got %b want 00", {m_ack, m_err}); end
            tick();
        end
    endtask

    task automatic test_timeout;
`ifdef XBUS_TIMEOUT_EN
        start(32'hF001_0000, 32'd0, 1'b0, 4'hF, 3'd0);
        for (int c = 2; c <= 11; c++) begin
            tick();
            checks++; if (m_err !== 1'b0) begin failures++;
                $display("FAIL tmo_early cycle %0d got %b want 0", c, m_err); end
        end
        tick();
        checks++; if ({m_err, err_ch, s_cyc} !== 9'b1_0001_0000) begin failures++;
            $display("FAIL tmo_err got %b want 100010000", {m_err, err_ch, s_cyc}); end
        m_cyc = 1'b0;
        tick();
        s_ack = 4'b0010;
        tick();
        s_ack = 4'b0000;
        checks++; if ({m_ack, m_err} !== 2'b00) begin failures++;
            $display("FAIL tmo_late got %b want 00", {m_ack, m_err}); end
        tick();
`else
        start(32'hF001_0000, 32'd0, 1'b0, 4'hF, 3'd0);
        for (int c = 2; c <= 31; c++) begin
            tick();
            checks++; if ({m_err, m_ack, s_cyc} !== 6'b00_0010) begin failures++;
                $display("FAIL hold cycle %0d got %b want 000010", c, {m_err, m_ack, s_cyc}); end
        end
        s_ack = 4'b0010; s_rdat[63:32] = 32'h5555_AAAA;
        tick();
        s_ack = 4'b0000;
        checks++; if ({m_ack, m_rdat} !== {1'b1, 32'h5555_AAAA}) begin failures++;
            $display("FAIL hold_ack got %h want 15555aaaa", {m_ack, m_rdat}); end
        m_cyc = 1'b0;
        tick();
`endif
    endtask

    task automatic test_reset_mid;
        start(32'hF002_0000, 32'hFFFF_FFFF, 1'b1, 4'hF, 3'b111);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; m_cyc = 1'b0;
        checks++; if ({m_ack, m_err, s_stb, s_cyc, err_ch, s_we, s_tag, s_sel} !== 22'd0) begin
            failures++;
            $display("FAIL rst_mid_ctrl got %h want 0",
                     {m_ack, m_err, s_stb, s_cyc, err_ch, s_we, s_tag, s_sel}); end
        checks++; if ({s_adr, s_dat, m_rdat} !== 96'd0) begin failures++;
            $display("FAIL rst_mid_bus got %h want 0", {s_adr, s_dat, m_rdat}); end
        tick();
        start(32'hF003_0040, 32'd0, 1'b0, 4'hF, 3'd0);
        checks++; if (s_stb !== 4'b1000) begin failures++;
            $display("FAIL rst_after_stb got %b want 1000", s_stb); end
        tick();
        s_ack = 4'b1000; s_rdat[127:96] = 32'h7777_0001;
        tick();
        s_ack = 4'b0000;
        checks++; if ({m_ack, m_rdat} !== {1'b1, 32'h7777_0001}) begin failures++;
            $display("FAIL rst_after_ack got %h want 177770001", {m_ack, m_rdat}); end
        m_cyc = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back;
        start(32'h0000_1000, 32'd0, 1'b0, 4'hF, 3'd0);
        tick();
        checks++; if (m_err !== 1'b1) begin failures++;
            $display("FAIL b2b_miss got %b want 1", m_err); end
        m_cyc = 1'b0;
        tick();
        start(32'hF000_0020, 32'd0, 1'b0, 4'hF, 3'd0);
        checks++; if (s_stb !== 4'b0001) begin failures++;
            $display("FAIL b2b_stb got %b want 0001", s_stb); end
        tick();
        s_ack = 4'b0001; s_rdat[31:0] = 32'hA5A5_0F0F;
        tick();
        s_ack = 4'b0000;
        checks++; if ({m_ack, m_rdat} !== {1'b1, 32'hA5A5_0F0F}) begin failures++;
            $display("FAIL b2b_ack got %h want 1a5a50f0f", {m_ack, m_rdat}); end
        m_cyc = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; m_adr = '0; m_dat = '0; m_tag = '0; m_we = 1'b0; m_sel = '0;
        m_stb = 1'b0; m_cyc = 1'b0; s_rdat = '0; s_ack = '0; s_err = '0;
        tick();
        test_reset();
        test_read();
        test_write();
        test_miss();
        test_slave_err();
        test_other_channel();
        test_abort();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/xbus_interconnect.md
# xbus_interconnect

Parametrised XBUS fabric between the neoRV32 core's external bus port and up to N_CH accelerator/memory slaves. It replaces the single hard-wired XBUS slave hookup of the accelerator build. It decodes the address into a channel and forwards one transaction at a time with registered request and response paths. Accesses outside the decoded window, and slaves that do not respond in time, receive a bus error.

## Interface
- N_CH, 4: number of slave channels, 1..16
- CH_AW, 16: log2 of each channel window in bytes
- BASE_ADDR, 32'hF000_0000: fabric base; must be aligned to N_CH·2^CH_AW
- TIMEOUT, 255: cycles to wait for slave ack/err before the fabric errors (only with XBUS_TIMEOUT_EN)

Ports:
- clk_i  in  1  clock; all logic on the rising edge
- rst_i  in  1  reset, synchronous, active-high
- m_adr_i  in  32  master address
- m_dat_i  in  32  master write data
- m_tag_i  in  3  access tag
- m_we_i  in  1  1 = write
- m_sel_i  in  4  byte enables
- m_stb_i  in  1  request strobe, one-cycle pulse
- m_cyc_i  in  1  cycle valid; held from stb until the response
- m_dat_o  out  32  read data, valid with m_ack_o
- m_ack_o  out  1  transfer acknowledge, one-cycle pulse
- m_err_o  out  1  transfer error, one-cycle pulse
- s_adr_o  out  32  forwarded address, shared by all channels
- s_dat_o  out  32  forwarded write data, shared
- s_tag_o  out  3  forwarded tag, shared
- s_we_o  out  1  forwarded write flag, shared
- s_sel_o  out  4  forwarded byte enables, shared
- s_stb_o  out  N_CH  per-channel strobe
- s_cyc_o  out  N_CH  per-channel cycle
- s_dat_i  in  32·N_CH  per-channel read data; channel k is bits [32k+31:32k]
- s_ack_i  in  N_CH  per-channel ack
- s_err_i  in  N_CH  per-channel error
- err_ch_o  out  4  channel index of the last slave error or timeout; 4'hF = decode miss

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - On m_stb_i, latch adr/dat/tag/we/sel.
  - Decode hit: adr[31:CH_AW+CW] == BASE_ADDR[31:CH_AW+CW], where CW = clog2(N_CH), max 1. The channel is adr[CH_AW+CW-1:CH_AW].
  - A channel index ≥ N_CH counts as a miss.
  - Hit → REQ. Miss → RESP with err, and err_ch_o ← 4'hF.
- REQ: s_stb_o[ch]=1 and s_cyc_o[ch]=1 for exactly one cycle → WAIT.
- WAIT:
  - s_cyc_o[ch] stays high.
  - On s_ack_i[ch]: capture s_dat_i[ch] → RESP with ack.
  - On s_err_i[ch]: → RESP with err, err_ch_o ← ch.
  - If ack and err arrive in the same cycle, err wins.
  - Strobes from non-selected channels are ignored.
- RESP: assert m_ack_o or m_err_o for one cycle; deassert s_cyc_o; → IDLE.
- m_dat_o is 0 unless m_ack_o is high on a read.
- Abort: m_cyc_i low in REQ or WAIT → drop s_cyc_o/s_stb_o next cycle, → IDLE, no master response.
- m_stb_i outside IDLE is ignored; the master guarantees one outstanding access.
- Reset (any state, including mid-transaction): state IDLE; all outputs 0 except err_ch_o = 0.

## Timing
- m_stb_i at cycle 0 → s_stb_o at cycle 1 (registered).
- s_ack_i at cycle k → m_ack_o at cycle k+1.
- Minimum hit latency: stb→ack = 3 cycles when the slave acks in the cycle after its strobe.
- Decode miss: m_err_o at cycle 2.
- All outputs are registered; there is no combinational path from any input to any output.
- Back-to-back: a new m_stb_i is accepted in the cycle after m_ack_o/m_err_o.

## Configuration
- XBUS_TIMEOUT_EN defined:
  - An 8-bit-minimum counter clears on entering REQ and increments in WAIT.
  - Reaching TIMEOUT → RESP with err, err_ch_o ← ch, s_cyc_o dropped.
  - A late slave ack after a timeout is ignored.
- Not defined: no counter; WAIT holds indefinitely until ack, err or abort.

## Structure
- Package xbus_pkg holds:
  - the state enum (IDLE/REQ/WAIT/RESP)
  - the constant ERR_CH_MISS = 4'hF
  - the XBUS width constants (ADR 32, DAT 32, TAG 3, SEL 4)
- One sub-module, xbus_addr_decode: combinational hit/channel decoder, parameterised by N_CH, CH_AW and BASE_ADDR.

## Test plan
- Read ch2, N_CH=4: m_adr_i=0xF002_0010 stb; slave 2 acks one cycle after its strobe with 0xCAFE_F00D → s_stb_o=4'b0100 at cycle 1; m_ack_o at cycle 3; m_dat_o=0xCAFE_F00D.
- Write ch0: adr 0xF000_0004, dat 0x1234_5678, sel 4'b0011 → s_dat_o, s_sel_o and s_we_o=1 forwarded; ack returned; m_dat_o=0.
- Miss: adr 0x8000_0000 → no s_stb_o; m_err_o at cycle 2; err_ch_o=4'hF.
- Slave error: ch3 asserts err and ack together → m_err_o only; err_ch_o=3.
- With XBUS_TIMEOUT_EN and TIMEOUT=10, ch1 silent → m_err_o 10 cycles after WAIT entry; a later s_ack_i[1] produces no master pulse.
- Abort and reset: m_cyc_i low in WAIT → s_cyc_o=0 next cycle, no response. rst_i high mid-WAIT → all outputs 0 next cycle; a following transaction completes normally.
